// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering one outstanding core load/store with a fixed access latency.
// Stores commit at the accept edge. Responses are held in RESP until the core takes them.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];
  logic              accept;
  logic              addr_err;
  logic              store_en;
  logic [ADDR_W-1:0] idx;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Reset held low blocks the accept, so no store can slip in during reset.
  assign accept   = req_valid && req_ready && reset;
  assign idx      = req_addr[ADDR_W+1:2];
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
  assign store_en = accept && req_we && !addr_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rdata_d = (addr_err || req_we) ? 32'h0 : mem_q[idx];
          err_d   = addr_err;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory contents survive reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 instance against a word/byte-mask memory model,
// plus a LATENCY=1 instance for back-to-back streaming.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl_mem  [1024];
  logic [3:0]  mdl_known[1024];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // One full transaction on the LATENCY=2 instance with rsp_ready held high.
  task automatic txn_a(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rd_obs);
    logic        exp_err;
    logic [31:0] exp_rd, mask;
    int          w, cyc;
    exp_err = (addr[1:0] != 0) || (addr[31:2] >= 32'd1024);
    w       = int'(addr[11:2]);
    if (exp_err || we) begin
      exp_rd = 0;
      mask   = 32'hFFFF_FFFF;
    end else begin
      exp_rd = mdl_mem[w];
      mask   = lane_mask(mdl_known[w]);
    end
    @(negedge clk);
    chk({tag, ".ready"}, 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    @(posedge clk);
    if (we && !exp_err) begin
      for (int i = 0; i < 4; i++) if (be[i]) mdl_mem[w][8*i +: 8] = wdata[8*i +: 8];
      mdl_known[w] = mdl_known[w] | be;
    end
    @(negedge clk);
    a_req_valid = 1'b0; a_req_we = $urandom_range(0, 1); a_req_addr = $urandom; a_req_wdata = $urandom;
    cyc = 1;
    while (!a_rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'd2);
    chk({tag, ".err"}, 32'(a_rsp_err), 32'(exp_err));
    chk({tag, ".rdata"}, a_rsp_rdata & mask, exp_rd & mask);
    rd_obs = a_rsp_rdata;
    @(negedge clk);
    chk({tag, ".done"}, {30'd0, a_rsp_valid, a_req_ready}, 32'b01);
  endtask

  initial begin
    logic [31:0] rd, hold_rd;
    logic        hold_err;
    int          cyc, accepts;
    for (int i = 0; i < 1024; i++) begin
      mdl_mem[i]   = '0;
      mdl_known[i] = 4'h0;
    end
    reset = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_rsp_ready = 1;
    repeat (3) @(negedge clk);
    chk("reset.state", {28'd0, a_req_ready, a_rsp_valid, a_rsp_err, 1'b0}, 32'b1000);
    chk("reset.rdata", a_rsp_rdata, 32'h0);
    reset = 1'b1;

    // Store then load back
    txn_a("st10", 1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    chk("st10.rdata0", rd, 32'h0);
    txn_a("ld10", 0, 32'h10, 32'h0, 4'h0, rd);
    chk("ld10.value", rd, 32'hDEADBEEF);

    // Partial byte-enable merge
    txn_a("st20a", 1, 32'h20, 32'h11223344, 4'hF, rd);
    txn_a("st20b", 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd);
    txn_a("ld20", 0, 32'h20, 32'h0, 4'hF, rd);
    chk("ld20.value", rd, 32'h11BB33DD);
    txn_a("st20z", 1, 32'h20, 32'hFFFFFFFF, 4'h0, rd);
    txn_a("ld20z", 0, 32'h20, 32'h0, 4'h0, rd);
    chk("ld20z.value", rd, 32'h11BB33DD);

    // Error cases; out-of-range store must not alias onto word 0
    txn_a("st0", 1, 32'h0, 32'h5A5A0F0F, 4'hF, rd);
    txn_a("ld13", 0, 32'h13, 32'h0, 4'hF, rd);
    txn_a("ld1000", 0, 32'h1000, 32'h0, 4'hF, rd);
    txn_a("st1000", 1, 32'h1000, 32'hCAFEF00D, 4'hF, rd);
    txn_a("ld0", 0, 32'h0, 32'h0, 4'hF, rd);
    chk("ld0.value", rd, 32'h5A5A0F0F);
    txn_a("ldtop", 0, 32'h0000_0FFC, 32'h0, 4'hF, rd);

    // Response held while rsp_ready is low
    a_rsp_ready = 1'b0;
    @(negedge clk);
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h10; a_req_be = 4'hF;
    @(negedge clk);
    a_req_valid = 0;
    cyc = 1;
    while (!a_rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold.latency", 32'(cyc), 32'd2);
    hold_rd = a_rsp_rdata; hold_err = a_rsp_err;
    chk("hold.first", hold_rd, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.stable", {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata == hold_rd}, {1'b1, 1'b0, hold_err, 1'b1});
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold.release", {30'd0, a_rsp_valid, a_req_ready}, 32'b01);

    // Reset during WAIT discards the pending response
    @(negedge clk);
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h20;
    @(negedge clk);
    a_req_valid = 0;
    chk("rstwait.inwait", {30'd0, a_rsp_valid, a_req_ready}, 32'b00);
    reset = 1'b0;
    @(negedge clk);
    chk("rstwait.after", {30'd0, a_rsp_valid, a_req_ready}, 32'b01);
    reset = 1'b1;
    cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_rsp_valid) cyc++;
    end
    chk("rstwait.noresp", 32'(cyc), 32'd0);
    txn_a("ld20r", 0, 32'h20, 32'h0, 4'hF, rd);

    // Reset together with req_valid: no accept, no store
    @(negedge clk);
    reset = 1'b0;
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h10; a_req_wdata = 32'h0BAD0BAD; a_req_be = 4'hF;
    @(negedge clk);
    a_req_valid = 0; reset = 1'b1;
    chk("rstreq.idle", {30'd0, a_rsp_valid, a_req_ready}, 32'b01);
    txn_a("ld10r", 0, 32'h10, 32'h0, 4'hF, rd);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] addr;
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0)      addr = {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
      else if (kind == 1) addr = 32'h1000 + ($urandom & 32'h7FFF_FFFC);
      else                addr = 32'h100 + 32'($urandom_range(0, 15) * 4);
      txn_a("rand", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), rd);
    end

    // LATENCY=1 instance streaming with req_valid and rsp_ready held high
    @(negedge clk);
    b_req_valid = 1; b_req_we = 1; b_req_addr = 32'h40; b_req_wdata = 32'h600DF00D; b_req_be = 4'hF;
    accepts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b_req_we = 0;
      chk("b2b.ready", 32'(b_req_ready), 32'(i % 2 == 1));
      chk("b2b.valid", 32'(b_rsp_valid), 32'(i % 2 == 0));
      if (b_rsp_valid) chk("b2b.rdata", b_rsp_rdata, (i == 0) ? 32'h0 : 32'h600DF00D);
      if (b_req_ready && b_req_valid) accepts++;
    end
    b_req_valid = 0;
    chk("b2b.accepts", 32'(accepts), 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data memory that answers load/store requests from the processor core's memory interface. The core issues requests; this block is the responding end. It holds one outstanding request, models a fixed access latency, and returns a response through a valid/ready handshake. It sits between the core's memory stage and on-chip SRAM.

## Interface

- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words
- LATENCY, 2, cycles from request accept to response valid; legal range 1..15

- clk  input  1  single clock; all logic on the rising edge
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- req_valid  input  1  core presents a request
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  store byte enables; bit i enables byte lane i (bits 8i+7:8i)
- rsp_valid  output  1  response available
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  request was misaligned or out of range

## Operation

- Accept occurs on a rising edge where req_valid && req_ready.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On accept, go to WAIT with countdown = LATENCY-1. If LATENCY=1, go directly to RESP.
  - WAIT: req_ready=0. Decrement countdown each cycle. When countdown reaches 0, go to RESP.
  - RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE.
- Address check is performed at accept:
  - err = (req_addr[1:0] != 0) || (req_addr[31:2] >= 2**ADDR_W).
  - Word index = req_addr[ADDR_W+1:2].
- Store without error: commit at the accept edge, updating only the lanes enabled by req_be. req_be=0 is legal, changes nothing, and gets a normal response.
- Store with error: memory is unchanged.
- Load: read the full word at the accept edge, ignoring req_be, and capture it into the response register.
- Error response: rsp_err=1 and rsp_rdata=0.
- All request inputs are ignored outside accept cycles.
- Only one request is outstanding at a time.

## Timing

- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, countdown=0. Memory contents are not reset.
- Latency: an accept at edge N gives rsp_valid=1 during the cycle after edge N+LATENCY-1, i.e. visible LATENCY cycles after the accept cycle.
- The handshake completes at the edge where rsp_valid && rsp_ready. rsp_valid falls and req_ready rises in the following cycle.
- There is no same-cycle response-complete and new-accept. Minimum request spacing is LATENCY+1 cycles.
- rsp_ready held low: the block stays in RESP indefinitely with outputs stable.
- rsp_ready high before rsp_valid has no effect.
- Read-after-write: a load accepted after a store's handshake returns the stored data.
- Reset asserted in any state forces reset values at that edge. Any pending response is discarded. A store already committed at accept is not undone.
- Reset and req_valid in the same cycle: reset wins and no accept occurs.
- Address wrap: no wrap-around. An index at or above the depth is an error, never aliased.

## Test plan

- Reset, then store addr 0x0000_0010, wdata 0xDEADBEEF, be 4'hF; then load 0x10. Required: each rsp_valid 2 cycles after accept (LATENCY=2); load returns 0xDEADBEEF with rsp_err=0.
- Store 0x11223344 to 0x20 with be 4'hF, then store 0xAABBCCDD to 0x20 with be 4'b0101, then load 0x20. Required: 0x11BB33DD.
- Load 0x0000_0013 and load 0x0000_1000 (ADDR_W=10). Required: both give rsp_err=1 and rsp_rdata=0. A store to 0x1000 leaves word 0 unchanged.
- Hold rsp_ready=0 for 5 cycles after rsp_valid. Required: rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0 throughout. Raising rsp_ready completes the handshake, and req_ready=1 on the next cycle.
- Accept a load, then drive reset low during WAIT. Required: the next cycle shows rsp_valid=0, req_ready=1 and no response ever appears.
- LATENCY=1 build: run back-to-back loads with req_valid and rsp_ready held high. Required: rsp_valid one cycle after each accept and an accept every 2 cycles.
